// File: rtl/autoseller_client_if.sv
// ---------------------------------------------------------------------------
// autoseller_client_if
// Groups every non-clock/reset signal of autoseller_client.
//   order_*  : order source -> client FIFO (valid/ready push interface)
//   sell_*   : client <-> autoseller, wired 1:1 to the seller's ports
//   result_* : one report per issued order
//   spurious_o, orders_done_o : status
// Modports:
//   master : the client itself (drives order_ready_o, sell_* requests, results)
//   slave  : the environment (order source + seller + result consumer)
// ---------------------------------------------------------------------------
interface autoseller_client_if;
    logic       order_valid_i;
    logic [5:0] order_money_i;
    logic [1:0] order_type_i;
    logic       order_ready_o;

    logic       sell_ready_i;
    logic       sell_enable_o;
    logic [5:0] sell_money_o;
    logic [1:0] sell_type_o;
    logic       sell_done_i;
    logic [5:0] sell_change_i;
    logic [1:0] sell_drink_i;

    logic       result_valid_o;
    logic [5:0] result_change_o;
    logic [1:0] result_drink_o;
    logic       result_ok_o;
    logic       result_timeout_o;
    logic       spurious_o;
    logic [7:0] orders_done_o;

    modport master (
        input  order_valid_i, order_money_i, order_type_i,
        output order_ready_o,
        input  sell_ready_i, sell_done_i, sell_change_i, sell_drink_i,
        output sell_enable_o, sell_money_o, sell_type_o,
        output result_valid_o, result_change_o, result_drink_o,
        output result_ok_o, result_timeout_o, spurious_o, orders_done_o
    );

    modport slave (
        output order_valid_i, order_money_i, order_type_i,
        input  order_ready_o,
        output sell_ready_i, sell_done_i, sell_change_i, sell_drink_i,
        input  sell_enable_o, sell_money_o, sell_type_o,
        input  result_valid_o, result_change_o, result_drink_o,
        input  result_ok_o, result_timeout_o, spurious_o, orders_done_o
    );
endinterface

// File: rtl/autoseller_client.sv
// ---------------------------------------------------------------------------
// autoseller_client
// Buyer-side driver for the autoseller enable/money/drinktype handshake.
// Orders are buffered in a DEPTH-entry FIFO and issued one at a time when the
// seller is ready. The seller's change/drink reply is checked against the
// price table and one result is reported per issued order.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-low reset
//   bus   : autoseller_client_if.master (order, seller and result signals)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a queued order and sell_ready_i
// S_ISSUE   | sell_enable_o high for one cycle with the head order
// S_WAIT    | waiting for sell_done_i, timer counting towards TIMEOUT
// S_REPORT  | result_* valid for one cycle
// ---------------------------------------------------------------------------
module autoseller_client #(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [5:0] PRICE0  = 6'd10,
    parameter logic [5:0] PRICE1  = 6'd15,
    parameter logic [5:0] PRICE2  = 6'd20,
    parameter logic [5:0] PRICE3  = 6'd25
) (
    input  logic                 clk,
    input  logic                 reset,
    autoseller_client_if.master  bus
);

    localparam int             AW          = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT    = (AW+1)'(DEPTH);
    localparam logic [7:0]     TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    // ---------------- order FIFO ----------------
    logic [5:0]    fifo_money [DEPTH];
    logic [1:0]    fifo_type  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_t        state;

    assign bus.order_ready_o = (count != FULL_CNT);
    assign push = bus.order_valid_i && bus.order_ready_o;
    // The head stays put through ISSUE and is retired on the edge leaving it.
    assign pop  = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_money[wr_ptr] <= bus.order_money_i;
                fifo_type[wr_ptr]  <= bus.order_type_i;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- reply check ----------------
    logic [5:0] ord_money;
    logic [1:0] ord_type;
    logic [5:0] price;
    logic       reply_ok;

    always_comb begin
        price = PRICE0;
        case (ord_type)
            2'b00: price = PRICE0;
            2'b01: price = PRICE1;
            2'b10: price = PRICE2;
            2'b11: price = PRICE3;
            default: price = PRICE0;
        endcase
        // Subtraction only matters when money covers the price, so it cannot wrap.
        if (ord_money >= price) begin
            reply_ok = (bus.sell_change_i == (ord_money - price)) &&
                       (bus.sell_drink_i == ord_type);
        end else begin
            reply_ok = (bus.sell_change_i == ord_money);
        end
    end

    // ---------------- control FSM ----------------
    logic [7:0] timer;
    logic       sell_enable;
    logic [5:0] sell_money;
    logic [1:0] sell_type;
    logic       result_valid;
    logic [5:0] result_change;
    logic [1:0] result_drink;
    logic       result_ok;
    logic       result_timeout;
    logic       spurious;
    logic [7:0] orders_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            ord_money      <= '0;
            ord_type       <= '0;
            sell_enable    <= 1'b0;
            sell_money     <= '0;
            sell_type      <= '0;
            result_valid   <= 1'b0;
            result_change  <= '0;
            result_drink   <= '0;
            result_ok      <= 1'b0;
            result_timeout <= 1'b0;
            spurious       <= 1'b0;
            orders_done    <= '0;
        end else begin
            if (bus.sell_done_i && (state != S_WAIT)) begin
                spurious <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if ((count != '0) && bus.sell_ready_i) begin
                        // Outputs are registered, so they are loaded on entry to ISSUE.
                        sell_enable <= 1'b1;
                        sell_money  <= fifo_money[rd_ptr];
                        sell_type   <= fifo_type[rd_ptr];
                        ord_money   <= fifo_money[rd_ptr];
                        ord_type    <= fifo_type[rd_ptr];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sell_enable <= 1'b0;
                    sell_money  <= '0;
                    sell_type   <= '0;
                    timer       <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.sell_done_i) begin
                        result_valid   <= 1'b1;
                        result_change  <= bus.sell_change_i;
                        result_drink   <= bus.sell_drink_i;
                        result_ok      <= reply_ok;
                        result_timeout <= 1'b0;
                        if (orders_done != 8'hFF) orders_done <= orders_done + 8'd1;
                        state          <= S_REPORT;
                    end else if ((timer + 8'd1) == TIMEOUT_CNT) begin
                        result_valid   <= 1'b1;
                        result_change  <= '0;
                        result_drink   <= '0;
                        result_ok      <= 1'b0;
                        result_timeout <= 1'b1;
                        if (orders_done != 8'hFF) orders_done <= orders_done + 8'd1;
                        state          <= S_REPORT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_REPORT: begin
                    result_valid   <= 1'b0;
                    result_change  <= '0;
                    result_drink   <= '0;
                    result_ok      <= 1'b0;
                    result_timeout <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sell_enable_o    = sell_enable;
    assign bus.sell_money_o     = sell_money;
    assign bus.sell_type_o      = sell_type;
    assign bus.result_valid_o   = result_valid;
    assign bus.result_change_o  = result_change;
    assign bus.result_drink_o   = result_drink;
    assign bus.result_ok_o      = result_ok;
    assign bus.result_timeout_o = result_timeout;
    assign bus.spurious_o       = spurious;
    assign bus.orders_done_o    = orders_done;

endmodule

// File: tb/tb_autoseller_client.sv
// ---------------------------------------------------------------------------
// tb_autoseller_client
// Directed bench for autoseller_client (DEPTH=4, TIMEOUT=15, prices 10/15/20/25).
// Expected issues and results are queued when an order is pushed and popped
// when the client issues / reports it.
// ---------------------------------------------------------------------------
module tb_autoseller_client;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    autoseller_client_if bus();

    autoseller_client #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] money;
        logic [1:0] dtype;
    } issue_t;

    typedef struct {
        logic [5:0] change;
        logic [1:0] drink;
        logic       ok;
        logic       timeout;
    } res_t;

    issue_t issue_q[$];
    res_t   res_q[$];
    int     errors = 0;
    int     checks = 0;
    int     model_count = 0;
    int     exp_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent price model: 10 + 5*type.
    function automatic logic model_ok(input int m, input int t, input int c, input int d);
        int p;
        p = 10 + 5 * t;
        if (m >= p) return (c == m - p) && (d == t);
        return (c == m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_order(input int m, input int t, input int rc, input int rd, input bit respond);
        issue_t it;
        res_t   r;
        bus.order_valid_i = 1'b1;
        bus.order_money_i = 6'(m);
        bus.order_type_i  = 2'(t);
        if (model_count < 4) begin
            it.money = 6'(m);
            it.dtype = 2'(t);
            issue_q.push_back(it);
            if (respond) begin
                r.change  = 6'(rc);
                r.drink   = 2'(rd);
                r.ok      = model_ok(m, t, rc, rd);
                r.timeout = 1'b0;
            end else begin
                r.change  = '0;
                r.drink   = '0;
                r.ok      = 1'b0;
                r.timeout = 1'b1;
            end
            res_q.push_back(r);
            model_count++;
        end
        tick();
        bus.order_valid_i = 1'b0;
        bus.order_money_i = '0;
        bus.order_type_i  = '0;
    endtask

    task automatic wait_result(input int budget, output int waited);
        res_t r;
        int   n = 0;
        while (bus.result_valid_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        waited = n;
        check("result_seen", bus.result_valid_o, 1);
        if (bus.result_valid_o === 1'b1 && res_q.size() > 0) begin
            r = res_q.pop_front();
            exp_done++;
            check("result_change",  bus.result_change_o,  r.change);
            check("result_drink",   bus.result_drink_o,   r.drink);
            check("result_ok",      bus.result_ok_o,      r.ok);
            check("result_timeout", bus.result_timeout_o, r.timeout);
            check("orders_done",    bus.orders_done_o,    exp_done);
        end
        tick();
        check("result_pulse_width", bus.result_valid_o, 0);
    endtask

    // Seller model: waits for the issue, replies `delay` cycles after it.
    task automatic serve(input int delay, input int rc, input int rd, input bit respond);
        issue_t it;
        int     n = 0;
        int     waited;
        while (bus.sell_enable_o !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("issue_seen", bus.sell_enable_o, 1);
        if (bus.sell_enable_o === 1'b1 && issue_q.size() > 0) begin
            it = issue_q.pop_front();
            model_count--;
            check("issue_money", bus.sell_money_o, it.money);
            check("issue_type",  bus.sell_type_o,  it.dtype);
        end
        tick();
        check("enable_pulse_width", bus.sell_enable_o, 0);
        check("money_idle_zero",    bus.sell_money_o,  0);
        for (int i = 1; i < delay; i++) tick();
        if (respond) begin
            bus.sell_done_i   = 1'b1;
            bus.sell_change_i = 6'(rc);
            bus.sell_drink_i  = 2'(rd);
            tick();
            bus.sell_done_i   = 1'b0;
            bus.sell_change_i = '0;
            bus.sell_drink_i  = '0;
            wait_result(30, waited);
            check("result_latency", waited, 0);
        end else begin
            wait_result(40, waited);
            check("timeout_cycles", waited, 15);
        end
    endtask

    int rc_tab[4];
    int rd_tab[4];
    int m, t, p;

    initial begin
        reset             = 1'b0;
        bus.order_valid_i = 1'b0;
        bus.order_money_i = '0;
        bus.order_type_i  = '0;
        bus.sell_ready_i  = 1'b0;
        bus.sell_done_i   = 1'b0;
        bus.sell_change_i = '0;
        bus.sell_drink_i  = '0;

        // 1: reset, then idle
        tick();
        tick();
        check("rst_order_ready",  bus.order_ready_o,    1);
        check("rst_sell_enable",  bus.sell_enable_o,    0);
        check("rst_sell_money",   bus.sell_money_o,     0);
        check("rst_sell_type",    bus.sell_type_o,      0);
        check("rst_result_valid", bus.result_valid_o,   0);
        check("rst_result_chg",   bus.result_change_o,  0);
        check("rst_result_ok",    bus.result_ok_o,      0);
        check("rst_result_to",    bus.result_timeout_o, 0);
        check("rst_spurious",     bus.spurious_o,       0);
        check("rst_orders_done",  bus.orders_done_o,    0);
        reset = 1'b1;
        bus.sell_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_enable", bus.sell_enable_o, 0);
        end

        // 2: single order, seller answers 3 cycles after enable
        push_order(30, 1, 15, 1, 1'b1);
        check("issue_not_before_latency", bus.sell_enable_o, 0);
        tick();
        check("issue_latency", bus.sell_enable_o, 1);
        serve(3, 15, 1, 1'b1);

        // 3: insufficient money, correct and wrong change
        push_order(8, 0, 8, 0, 1'b1);
        serve(2, 8, 0, 1'b1);
        push_order(8, 0, 0, 0, 1'b1);
        serve(2, 0, 0, 1'b1);

        // 4: fill the FIFO while seller busy, then drain in order
        bus.sell_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m = 20 + i;
            t = i % 4;
            p = 10 + 5 * t;
            if (i < 4) begin
                rc_tab[i] = (m >= p) ? m - p : m;
                rd_tab[i] = (m >= p) ? t : 0;
            end
            push_order(m, t, (m >= p) ? m - p : m, (m >= p) ? t : 0, 1'b1);
            check("order_ready_fill", bus.order_ready_o, (model_count < 4) ? 1 : 0);
        end
        check("no_issue_while_busy", bus.sell_enable_o, 0);
        bus.sell_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(2, rc_tab[i], rd_tab[i], 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drained_no_issue", bus.sell_enable_o, 0);
        end
        check("drained_order_ready", bus.order_ready_o, 1);

        // 5: timeout, then next queued order proceeds normally
        push_order(40, 2, 0, 0, 1'b0);
        push_order(12, 1, 12, 1, 1'b1);
        serve(1, 0, 0, 1'b0);
        serve(2, 12, 1, 1'b1);

        // 6a: spurious done in IDLE
        tick();
        bus.sell_done_i   = 1'b1;
        bus.sell_change_i = 6'd5;
        tick();
        bus.sell_done_i   = 1'b0;
        bus.sell_change_i = '0;
        check("spurious_set",         bus.spurious_o,     1);
        check("spurious_no_result",   bus.result_valid_o, 0);
        tick();
        check("spurious_no_result2",  bus.result_valid_o, 0);
        check("spurious_sticky",      bus.spurious_o,     1);
        check("spurious_orders_done", bus.orders_done_o,  exp_done);

        // 6b: reset during WAIT_DONE drops in-flight order and FIFO
        push_order(50, 3, 25, 3, 1'b1);
        push_order(33, 0, 23, 0, 1'b1);
        check("rst6_issue_seen", bus.sell_enable_o, 1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        issue_q.delete();
        res_q.delete();
        model_count = 0;
        exp_done    = 0;
        check("rst6_order_ready",  bus.order_ready_o,  1);
        check("rst6_result_valid", bus.result_valid_o, 0);
        check("rst6_spurious",     bus.spurious_o,     0);
        check("rst6_orders_done",  bus.orders_done_o,  0);
        for (int i = 0; i < 25; i++) begin
            tick();
            check("rst6_fifo_empty", bus.sell_enable_o, 0);
            check("rst6_no_result",  bus.result_valid_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
